// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: after each key event it scans the voices one per cycle, then issues a
// single-cycle load command that retriggers a matching voice, takes a free one, or steals the oldest.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7,
    parameter int AGE_W      = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic                          key_on,
    input  logic [NOTE_W-1:0]             key_note,
    output logic                          key_ready,
    output logic                          load_valid,
    output logic [$clog2(NUM_VOICES)-1:0] load_voice,
    output logic [NOTE_W-1:0]             load_note,
    output logic                          load_gate,
    output logic                          steal_pulse,
    output logic [NUM_VOICES-1:0]         voice_busy
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  key_ready_q, key_ready_d;
    logic                  key_on_q, key_on_d;
    logic [NOTE_W-1:0]     key_note_q, key_note_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;

    logic                  match_found_q, match_found_d, match_found_s;
    logic [IDX_W-1:0]      match_idx_q, match_idx_d, match_idx_s;
    logic                  free_found_q, free_found_d, free_found_s;
    logic [IDX_W-1:0]      free_idx_q, free_idx_d, free_idx_s;
    logic                  oldest_found_q, oldest_found_d, oldest_found_s;
    logic [IDX_W-1:0]      oldest_idx_q, oldest_idx_d, oldest_idx_s;
    logic [AGE_W-1:0]      oldest_age_q, oldest_age_d, oldest_age_s;

    logic [NUM_VOICES-1:0] busy_q, busy_d;
    logic [NOTE_W-1:0]     note_q [NUM_VOICES];
    logic [NOTE_W-1:0]     note_d [NUM_VOICES];
    logic [AGE_W-1:0]      age_q  [NUM_VOICES];
    logic [AGE_W-1:0]      age_d  [NUM_VOICES];

    logic                  load_valid_q, load_valid_d;
    logic [IDX_W-1:0]      load_voice_q, load_voice_d;
    logic [NOTE_W-1:0]     load_note_q, load_note_d;
    logic                  load_gate_q, load_gate_d;
    logic                  steal_q, steal_d;

    logic                  cur_busy_s;
    logic [NOTE_W-1:0]     cur_note_s;
    logic [AGE_W-1:0]      cur_age_s;
    logic [IDX_W-1:0]      target_s;
    logic                  have_target_s;
    logic                  steal_s;

    assign key_ready   = key_ready_q;
    assign load_valid  = load_valid_q;
    assign load_voice  = load_voice_q;
    assign load_note   = load_note_q;
    assign load_gate   = load_gate_q;
    assign steal_pulse = steal_q;
    assign voice_busy  = busy_q;

    // Fold the voice under the scan pointer into the running match/free/oldest results
    always_comb begin
        cur_busy_s = busy_q[scan_idx_q];
        cur_note_s = note_q[scan_idx_q];
        cur_age_s  = age_q[scan_idx_q];

        if (cur_busy_s && !match_found_q && (cur_note_s == key_note_q)) begin
            match_found_s = 1'b1;
            match_idx_s   = scan_idx_q;
        end else begin
            match_found_s = match_found_q;
            match_idx_s   = match_idx_q;
        end

        if (!cur_busy_s && !free_found_q) begin
            free_found_s = 1'b1;
            free_idx_s   = scan_idx_q;
        end else begin
            free_found_s = free_found_q;
            free_idx_s   = free_idx_q;
        end

        // Strict compare keeps the lowest index on equal ages
        if (cur_busy_s && (!oldest_found_q || (cur_age_s > oldest_age_q))) begin
            oldest_found_s = 1'b1;
            oldest_idx_s   = scan_idx_q;
            oldest_age_s   = cur_age_s;
        end else begin
            oldest_found_s = oldest_found_q;
            oldest_idx_s   = oldest_idx_q;
            oldest_age_s   = oldest_age_q;
        end
    end

    // Press target priority: retrigger a match, else a free voice, else steal the oldest
    always_comb begin
        target_s      = {IDX_W{1'b0}};
        have_target_s = 1'b0;
        steal_s       = 1'b0;
        if (match_found_s) begin
            target_s      = match_idx_s;
            have_target_s = 1'b1;
        end else if (free_found_s) begin
            target_s      = free_idx_s;
            have_target_s = 1'b1;
        end else if (oldest_found_s) begin
            target_s      = oldest_idx_s;
            have_target_s = 1'b1;
            steal_s       = 1'b1;
        end else begin
            have_target_s = 1'b0;
        end
    end

    // Next-state, voice table update and load command generation
    always_comb begin
        state_d        = state_q;
        key_on_d       = key_on_q;
        key_note_d     = key_note_q;
        scan_idx_d     = scan_idx_q;
        match_found_d  = match_found_q;
        match_idx_d    = match_idx_q;
        free_found_d   = free_found_q;
        free_idx_d     = free_idx_q;
        oldest_found_d = oldest_found_q;
        oldest_idx_d   = oldest_idx_q;
        oldest_age_d   = oldest_age_q;
        busy_d         = busy_q;
        note_d         = note_q;
        age_d          = age_q;
        load_valid_d   = 1'b0;
        load_gate_d    = 1'b0;
        steal_d        = 1'b0;
        load_voice_d   = load_voice_q;
        load_note_d    = load_note_q;

        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    state_d        = ST_SCAN;
                    key_on_d       = key_on;
                    key_note_d     = key_note;
                    scan_idx_d     = {IDX_W{1'b0}};
                    match_found_d  = 1'b0;
                    match_idx_d    = {IDX_W{1'b0}};
                    free_found_d   = 1'b0;
                    free_idx_d     = {IDX_W{1'b0}};
                    oldest_found_d = 1'b0;
                    oldest_idx_d   = {IDX_W{1'b0}};
                    oldest_age_d   = {AGE_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (scan_idx_q != LAST_IDX) begin
                    scan_idx_d     = scan_idx_q + IDX_W'(1);
                    match_found_d  = match_found_s;
                    match_idx_d    = match_idx_s;
                    free_found_d   = free_found_s;
                    free_idx_d     = free_idx_s;
                    oldest_found_d = oldest_found_s;
                    oldest_idx_d   = oldest_idx_s;
                    oldest_age_d   = oldest_age_s;
                end else begin
                    // Last voice examined: commit the decision so the load is visible during ISSUE
                    state_d = ST_ISSUE;
                    if (key_on_q) begin
                        if (have_target_s) begin
                            load_valid_d = 1'b1;
                            load_gate_d  = 1'b1;
                            steal_d      = steal_s;
                            load_voice_d = target_s;
                            load_note_d  = key_note_q;
                            for (int v = 0; v < NUM_VOICES; v++) begin
                                if (IDX_W'(v) == target_s) begin
                                    busy_d[v] = 1'b1;
                                    note_d[v] = key_note_q;
                                    age_d[v]  = {AGE_W{1'b0}};
                                end else if (busy_q[v]) begin
                                    age_d[v] = (age_q[v] == AGE_MAX) ? AGE_MAX : (age_q[v] + AGE_W'(1));
                                end else begin
                                    age_d[v] = age_q[v];
                                end
                            end
                        end else begin
                            load_valid_d = 1'b0;
                        end
                    end else if (match_found_s) begin
                        load_valid_d        = 1'b1;
                        load_gate_d         = 1'b0;
                        load_voice_d        = match_idx_s;
                        load_note_d         = key_note_q;
                        busy_d[match_idx_s] = 1'b0;
                    end else begin
                        load_valid_d = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        key_ready_d = (state_d == ST_IDLE);
    end

    // State, voice table and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            key_ready_q    <= 1'b1;
            key_on_q       <= 1'b0;
            key_note_q     <= {NOTE_W{1'b0}};
            scan_idx_q     <= {IDX_W{1'b0}};
            match_found_q  <= 1'b0;
            match_idx_q    <= {IDX_W{1'b0}};
            free_found_q   <= 1'b0;
            free_idx_q     <= {IDX_W{1'b0}};
            oldest_found_q <= 1'b0;
            oldest_idx_q   <= {IDX_W{1'b0}};
            oldest_age_q   <= {AGE_W{1'b0}};
            busy_q         <= {NUM_VOICES{1'b0}};
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= {NOTE_W{1'b0}};
                age_q[v]  <= {AGE_W{1'b0}};
            end
            load_valid_q   <= 1'b0;
            load_voice_q   <= {IDX_W{1'b0}};
            load_note_q    <= {NOTE_W{1'b0}};
            load_gate_q    <= 1'b0;
            steal_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_ready_q    <= key_ready_d;
            key_on_q       <= key_on_d;
            key_note_q     <= key_note_d;
            scan_idx_q     <= scan_idx_d;
            match_found_q  <= match_found_d;
            match_idx_q    <= match_idx_d;
            free_found_q   <= free_found_d;
            free_idx_q     <= free_idx_d;
            oldest_found_q <= oldest_found_d;
            oldest_idx_q   <= oldest_idx_d;
            oldest_age_q   <= oldest_age_d;
            busy_q         <= busy_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= note_d[v];
                age_q[v]  <= age_d[v];
            end
            load_valid_q   <= load_valid_d;
            load_voice_q   <= load_voice_d;
            load_note_q    <= load_note_d;
            load_gate_q    <= load_gate_d;
            steal_q        <= steal_d;
        end
    end

endmodule
